// File: rtl/router_pkg.sv
// Shared types and constants for the 1x3 router input side (FSM, synchronizer, register block).
package router_pkg;

    localparam int          NUM_PORTS = 3;
    localparam int          ADDR_W    = 2;
    localparam logic [1:0]  BAD_ADDR  = 2'b11;

    typedef logic [ADDR_W-1:0] port_idx_t;

    typedef enum logic [2:0] {
        DECODE_ADDRESS     = 3'd0,
        LOAD_FIRST_DATA    = 3'd1,
        LOAD_DATA          = 3'd2,
        LOAD_PARITY        = 3'd3,
        FIFO_FULL_STATE    = 3'd4,
        LOAD_AFTER_FULL    = 3'd5,
        WAIT_TILL_EMPTY    = 3'd6,
        CHECK_PARITY_ERROR = 3'd7
    } state_t;

endpackage

// File: rtl/router_fsm_if.sv
// Control bundle between the router FSM and its neighbours (source, synchronizer, register block).
interface router_fsm_if;
    import router_pkg::*;

    logic      pkt_valid;
    port_idx_t din;
    logic      fifo_full;
    logic      fifo_empty_0;
    logic      fifo_empty_1;
    logic      fifo_empty_2;
    logic      soft_reset_0;
    logic      soft_reset_1;
    logic      soft_reset_2;
    logic      parity_done;
    logic      low_pkt_valid;

    logic      detect_addr;
    logic      lfd_state;
    logic      ld_state;
    logic      laf_state;
    logic      full_state;
    logic      wr_en_reg;
    logic      rst_int_reg;
    logic      busy;

    modport master (
        output pkt_valid, din, fifo_full,
        output fifo_empty_0, fifo_empty_1, fifo_empty_2,
        output soft_reset_0, soft_reset_1, soft_reset_2,
        output parity_done, low_pkt_valid,
        input  detect_addr, lfd_state, ld_state, laf_state,
        input  full_state, wr_en_reg, rst_int_reg, busy
    );

    modport slave (
        input  pkt_valid, din, fifo_full,
        input  fifo_empty_0, fifo_empty_1, fifo_empty_2,
        input  soft_reset_0, soft_reset_1, soft_reset_2,
        input  parity_done, low_pkt_valid,
        output detect_addr, lfd_state, ld_state, laf_state,
        output full_state, wr_en_reg, rst_int_reg, busy
    );

endinterface

// File: rtl/router_fsm.sv
// Input-side control FSM of the 1x3 packet router: decodes the header destination,
// sequences header/payload/parity loads, stalls on a full FIFO and abandons on soft reset.
module router_fsm #(
    parameter int                NUM_PORTS = router_pkg::NUM_PORTS,
    parameter int                ADDR_W    = router_pkg::ADDR_W,
    parameter logic [ADDR_W-1:0] BAD_ADDR  = router_pkg::BAD_ADDR
) (
    input  logic         clk,
    input  logic         rst,
    router_fsm_if.slave  bus
);
    import router_pkg::*;

    if (NUM_PORTS != 3) begin : g_num_ports_check
        $error("router_fsm: only NUM_PORTS = 3 is supported");
    end
    if (ADDR_W != $bits(port_idx_t)) begin : g_addr_w_check
        $error("router_fsm: ADDR_W must match router_pkg::port_idx_t");
    end

    state_t            state;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] sel_idx;
    logic              sel_empty;
    logic              sel_soft_reset;
    logic              hdr_ok;

    function automatic logic sel_flag(input logic [ADDR_W-1:0] idx,
                                      input logic [NUM_PORTS-1:0] flags);
        logic r;
        r = 1'b0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (idx == ADDR_W'(i)) r = flags[i];
        end
        return r;
    endfunction

    // While decoding, the address register is not yet loaded, so look at din directly.
    assign sel_idx        = (state == DECODE_ADDRESS) ? bus.din : addr_q;
    assign sel_empty      = sel_flag(sel_idx,
                                     {bus.fifo_empty_2, bus.fifo_empty_1, bus.fifo_empty_0});
    assign sel_soft_reset = sel_flag(addr_q,
                                     {bus.soft_reset_2, bus.soft_reset_1, bus.soft_reset_0});
    assign hdr_ok         = bus.pkt_valid && (bus.din != BAD_ADDR);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= DECODE_ADDRESS;
            addr_q <= '0;
        end else begin
            if (state == DECODE_ADDRESS && hdr_ok) addr_q <= bus.din;

            // A soft reset of the selected FIFO abandons the packet from any active state.
            if (state != DECODE_ADDRESS && sel_soft_reset) begin
                state <= DECODE_ADDRESS;
            end else begin
                case (state)
                    DECODE_ADDRESS: begin
                        if (hdr_ok) state <= sel_empty ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
                    end
                    WAIT_TILL_EMPTY: begin
                        if (sel_empty) state <= LOAD_FIRST_DATA;
                    end
                    LOAD_FIRST_DATA: state <= LOAD_DATA;
                    LOAD_DATA: begin
                        if (bus.fifo_full)       state <= FIFO_FULL_STATE;
                        else if (!bus.pkt_valid) state <= LOAD_PARITY;
                    end
                    FIFO_FULL_STATE: begin
                        if (!bus.fifo_full) state <= LOAD_AFTER_FULL;
                    end
                    LOAD_AFTER_FULL: begin
                        if (bus.parity_done)        state <= DECODE_ADDRESS;
                        else if (bus.low_pkt_valid) state <= LOAD_PARITY;
                        else                        state <= LOAD_DATA;
                    end
                    LOAD_PARITY: state <= CHECK_PARITY_ERROR;
                    CHECK_PARITY_ERROR: begin
                        state <= bus.fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
                    end
                    default: state <= DECODE_ADDRESS;
                endcase
            end
        end
    end

    assign bus.detect_addr = (state == DECODE_ADDRESS);
    assign bus.lfd_state   = (state == LOAD_FIRST_DATA);
    assign bus.ld_state    = (state == LOAD_DATA);
    assign bus.laf_state   = (state == LOAD_AFTER_FULL);
    assign bus.full_state  = (state == FIFO_FULL_STATE);
    assign bus.rst_int_reg = (state == CHECK_PARITY_ERROR);
    assign bus.wr_en_reg   = (state == LOAD_DATA) || (state == LOAD_PARITY) ||
                             (state == LOAD_AFTER_FULL);
    assign bus.busy        = (state != DECODE_ADDRESS) && (state != LOAD_DATA);

endmodule

// File: tb/tb_router_fsm.sv
// Directed table-driven bench for router_fsm with hand-computed Moore output patterns.
module tb_router_fsm;

    // Output pattern: {detect_addr, lfd, ld, laf, full, wr_en_reg, rst_int_reg, busy}
    localparam logic [7:0] O_DA  = 8'b1000_0000;
    localparam logic [7:0] O_LFD = 8'b0100_0001;
    localparam logic [7:0] O_LD  = 8'b0010_0100;
    localparam logic [7:0] O_LAF = 8'b0001_0101;
    localparam logic [7:0] O_FUL = 8'b0000_1001;
    localparam logic [7:0] O_LP  = 8'b0000_0101;
    localparam logic [7:0] O_CPE = 8'b0000_0011;
    localparam logic [7:0] O_WTE = 8'b0000_0001;

    typedef struct {
        logic       pv;
        logic [1:0] din;
        logic       ff;
        logic [2:0] emp;
        logic [2:0] sr;
        logic       pd;
        logic       lpv;
        logic [7:0] exp;
    } vec_t;

    logic clk;
    logic rst;
    int   nvec;
    int   nfail;
    int   wr_cnt;
    vec_t tbl[$];

    router_fsm_if bus();

    router_fsm dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic vec_t mk(input logic pv, input logic [1:0] din, input logic ff,
                                input logic [2:0] emp, input logic [2:0] sr,
                                input logic pd, input logic lpv, input logic [7:0] exp);
        vec_t v;
        v.pv = pv; v.din = din; v.ff = ff; v.emp = emp;
        v.sr = sr; v.pd = pd; v.lpv = lpv; v.exp = exp;
        return v;
    endfunction

    function automatic logic [7:0] outs();
        return {bus.detect_addr, bus.lfd_state, bus.ld_state, bus.laf_state,
                bus.full_state, bus.wr_en_reg, bus.rst_int_reg, bus.busy};
    endfunction

    task automatic drive(input vec_t v);
        bus.pkt_valid     = v.pv;
        bus.din           = v.din;
        bus.fifo_full     = v.ff;
        {bus.fifo_empty_2, bus.fifo_empty_1, bus.fifo_empty_0} = v.emp;
        {bus.soft_reset_2, bus.soft_reset_1, bus.soft_reset_0} = v.sr;
        bus.parity_done   = v.pd;
        bus.low_pkt_valid = v.lpv;
    endtask

    task automatic check(input string name, input logic [7:0] exp);
        logic [7:0] act;
        act = outs();
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: outputs %b, expected %b", name, act, exp);
        end
    endtask

    task automatic apply(input vec_t v, input string name);
        drive(v);
        @(posedge clk);
        #1;
        check(name, v.exp);
    endtask

    initial begin
        nvec   = 0;
        nfail  = 0;
        wr_cnt = 0;
        rst    = 1'b0;
        drive(mk(0, 2'b00, 0, 3'b111, 3'b000, 0, 0, O_DA));

        // 1: legal header to port 1, three valid cycles, then parity and check
        tbl.push_back(mk(1, 2'b01, 0, 3'b111, 3'b000, 0, 0, O_LFD));
        tbl.push_back(mk(1, 2'b01, 0, 3'b111, 3'b000, 0, 0, O_LD));
        tbl.push_back(mk(1, 2'b01, 0, 3'b111, 3'b000, 0, 0, O_LD));
        tbl.push_back(mk(0, 2'b01, 0, 3'b111, 3'b000, 0, 0, O_LP));
        tbl.push_back(mk(0, 2'b01, 0, 3'b111, 3'b000, 0, 0, O_CPE));
        tbl.push_back(mk(0, 2'b01, 0, 3'b111, 3'b000, 0, 0, O_DA));
        // 6: illegal address held for five cycles
        for (int i = 0; i < 5; i++) tbl.push_back(mk(1, 2'b11, 0, 3'b111, 3'b000, 0, 0, O_DA));
        // 11: port 2 not empty for four cycles, then empty
        for (int i = 0; i < 4; i++) tbl.push_back(mk(1, 2'b10, 0, 3'b011, 3'b000, 0, 0, O_WTE));
        tbl.push_back(mk(1, 2'b10, 0, 3'b111, 3'b000, 0, 0, O_LFD));
        tbl.push_back(mk(1, 2'b10, 0, 3'b111, 3'b000, 0, 0, O_LD));
        // 17: full for three cycles, release with low_pkt_valid
        for (int i = 0; i < 3; i++) tbl.push_back(mk(1, 2'b10, 1, 3'b111, 3'b000, 0, 0, O_FUL));
        tbl.push_back(mk(0, 2'b10, 0, 3'b111, 3'b000, 0, 1, O_LAF));
        tbl.push_back(mk(0, 2'b10, 0, 3'b111, 3'b000, 0, 1, O_LP));
        tbl.push_back(mk(0, 2'b10, 0, 3'b111, 3'b000, 0, 0, O_CPE));
        tbl.push_back(mk(0, 2'b10, 0, 3'b111, 3'b000, 0, 0, O_DA));
        // 24: full beats !pkt_valid; LAF back to LD; LAF with parity_done to DA
        tbl.push_back(mk(1, 2'b00, 0, 3'b111, 3'b000, 0, 0, O_LFD));
        tbl.push_back(mk(1, 2'b00, 0, 3'b111, 3'b000, 0, 0, O_LD));
        tbl.push_back(mk(0, 2'b00, 1, 3'b111, 3'b000, 0, 0, O_FUL));
        tbl.push_back(mk(1, 2'b00, 0, 3'b111, 3'b000, 0, 0, O_LAF));
        tbl.push_back(mk(1, 2'b00, 0, 3'b111, 3'b000, 0, 0, O_LD));
        tbl.push_back(mk(1, 2'b00, 1, 3'b111, 3'b000, 0, 0, O_FUL));
        tbl.push_back(mk(0, 2'b00, 0, 3'b111, 3'b000, 0, 0, O_LAF));
        tbl.push_back(mk(0, 2'b00, 0, 3'b111, 3'b000, 1, 1, O_DA));
        // 32: check-parity with FIFO full goes to FULL
        tbl.push_back(mk(1, 2'b00, 0, 3'b111, 3'b000, 0, 0, O_LFD));
        tbl.push_back(mk(1, 2'b00, 0, 3'b111, 3'b000, 0, 0, O_LD));
        tbl.push_back(mk(0, 2'b00, 0, 3'b111, 3'b000, 0, 0, O_LP));
        tbl.push_back(mk(0, 2'b00, 0, 3'b111, 3'b000, 0, 0, O_CPE));
        tbl.push_back(mk(0, 2'b00, 1, 3'b111, 3'b000, 0, 0, O_FUL));
        tbl.push_back(mk(0, 2'b00, 0, 3'b111, 3'b000, 0, 0, O_LAF));
        tbl.push_back(mk(0, 2'b00, 0, 3'b111, 3'b000, 1, 0, O_DA));
        // 39: soft reset of a foreign port ignored, of the selected port aborts
        tbl.push_back(mk(1, 2'b00, 0, 3'b111, 3'b000, 0, 0, O_LFD));
        tbl.push_back(mk(1, 2'b00, 0, 3'b111, 3'b000, 0, 0, O_LD));
        tbl.push_back(mk(1, 2'b00, 0, 3'b111, 3'b010, 0, 0, O_LD));
        tbl.push_back(mk(1, 2'b00, 0, 3'b111, 3'b011, 0, 0, O_DA));
        tbl.push_back(mk(0, 2'b00, 0, 3'b111, 3'b001, 0, 0, O_DA));
        // 44: soft reset overrides fifo_full
        tbl.push_back(mk(1, 2'b00, 0, 3'b111, 3'b000, 0, 0, O_LFD));
        tbl.push_back(mk(1, 2'b00, 0, 3'b111, 3'b000, 0, 0, O_LD));
        tbl.push_back(mk(1, 2'b00, 1, 3'b111, 3'b001, 0, 0, O_DA));
        // 47: WTE watches the latched address, not din; soft reset from LFD
        tbl.push_back(mk(1, 2'b01, 0, 3'b101, 3'b000, 0, 0, O_WTE));
        tbl.push_back(mk(1, 2'b10, 0, 3'b101, 3'b000, 0, 0, O_WTE));
        tbl.push_back(mk(1, 2'b10, 0, 3'b111, 3'b000, 0, 0, O_LFD));
        tbl.push_back(mk(0, 2'b10, 0, 3'b111, 3'b010, 0, 0, O_DA));

        #12;
        check("reset_outputs", O_DA);
        rst = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i], $sformatf("vec%0d", i));
            if (i < 6 && bus.wr_en_reg === 1'b1) wr_cnt++;
        end
        nvec++;
        if (wr_cnt != 3) begin
            nfail++;
            $display("FAIL wr_en_count: %0d cycles, expected 3", wr_cnt);
        end

        // Asynchronous reset in the middle of a full stall
        apply(mk(1, 2'b00, 0, 3'b111, 3'b000, 0, 0, O_LFD), "ar_lfd");
        apply(mk(1, 2'b00, 0, 3'b111, 3'b000, 0, 0, O_LD),  "ar_ld");
        apply(mk(1, 2'b00, 1, 3'b111, 3'b000, 0, 0, O_FUL), "ar_full");
        #3;
        rst = 1'b0;
        #1;
        check("async_rst_no_edge", O_DA);
        @(posedge clk);
        #1;
        check("rst_held", O_DA);
        rst = 1'b1;
        apply(mk(0, 2'b00, 0, 3'b111, 3'b000, 0, 0, O_DA),  "post_rst_idle");
        apply(mk(1, 2'b10, 0, 3'b111, 3'b000, 0, 0, O_LFD), "post_rst_lfd");
        apply(mk(1, 2'b10, 0, 3'b111, 3'b000, 0, 0, O_LD),  "post_rst_ld");
        apply(mk(0, 2'b10, 0, 3'b111, 3'b000, 0, 0, O_LP),  "post_rst_lp");
        apply(mk(0, 2'b10, 0, 3'b111, 3'b000, 0, 0, O_CPE), "post_rst_cpe");
        apply(mk(0, 2'b10, 0, 3'b111, 3'b000, 0, 0, O_DA),  "post_rst_da");

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule

// File: doc/router_fsm.md
Name: router_fsm

Overview:
- Control FSM of the 1x3 packet router input side; sits directly upstream of the router synchronizer and the three output FIFOs.
- Watches the incoming packet stream (header, payload, parity) and decodes the destination from the header.
- Drives detect_addr and wr_en_reg into the synchronizer, plus load/flag strobes into the register block.
- Stalls on fifo_full and abandons a packet when the destination FIFO is soft-reset.

Parameters:
- NUM_PORTS, 3, number of output ports; only 3 is supported, and other values are rejected at elaboration.
- ADDR_W, 2, width of the destination address field (din).
- BAD_ADDR, 2'b11, address value that is never accepted.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-low reset
- pkt_valid  input  1  high while header/payload bytes are presented; falls on the parity byte
- din  input  ADDR_W  destination address bits of the header byte
- fifo_full  input  1  full flag of the currently selected FIFO, from the synchronizer
- fifo_empty_0, fifo_empty_1, fifo_empty_2  input  1 each  empty flags of the FIFOs
- soft_reset_0, soft_reset_1, soft_reset_2  input  1 each  soft resets from the synchronizer
- parity_done  input  1  parity byte already captured, from the register block
- low_pkt_valid  input  1  pkt_valid fell while the FIFO was full, from the register block
- detect_addr  output  1  header decode window; the synchronizer latches din when this is high
- lfd_state  output  1  load first data (header) cycle
- ld_state  output  1  load payload cycle
- laf_state  output  1  load-after-full cycle
- full_state  output  1  stalled on full FIFO
- wr_en_reg  output  1  FIFO write request to the synchronizer
- rst_int_reg  output  1  parity check cycle; the register block clears its internal state
- busy  output  1  input source must hold its data

Behaviour:
- **State register:** the state and addr_q (ADDR_W) use an asynchronous active-low reset. While rst=0, state=DECODE_ADDRESS and addr_q=0.
- **Outputs:** all outputs are Moore and decoded combinationally from state. Because reset forces DECODE_ADDRESS, the reset values are detect_addr=1 and every other output 0.
- **Output decode:**
  - detect_addr = DECODE_ADDRESS
  - lfd_state = LOAD_FIRST_DATA
  - ld_state = LOAD_DATA
  - laf_state = LOAD_AFTER_FULL
  - full_state = FIFO_FULL_STATE
  - rst_int_reg = CHECK_PARITY_ERROR
  - wr_en_reg = LOAD_DATA, LOAD_PARITY or LOAD_AFTER_FULL
  - busy = 1 in every state except DECODE_ADDRESS and LOAD_DATA
- **Address capture:** addr_q <= din on any DECODE_ADDRESS cycle with pkt_valid=1 and din!=BAD_ADDR. sel_empty = fifo_empty_[addr_q], except that in DECODE_ADDRESS it is fifo_empty_[din].
- **DECODE_ADDRESS:**
  - pkt_valid & din!=BAD_ADDR & sel_empty -> LOAD_FIRST_DATA
  - pkt_valid & din!=BAD_ADDR & !sel_empty -> WAIT_TILL_EMPTY
  - otherwise stay; an illegal address is ignored and no write occurs
- **WAIT_TILL_EMPTY:** sel_empty -> LOAD_FIRST_DATA; else stay.
- **LOAD_FIRST_DATA:** -> LOAD_DATA unconditionally (one cycle).
- **LOAD_DATA:** fifo_full -> FIFO_FULL_STATE; else !pkt_valid -> LOAD_PARITY; else stay. fifo_full has priority.
- **FIFO_FULL_STATE:** !fifo_full -> LOAD_AFTER_FULL; else stay.
- **LOAD_AFTER_FULL:** parity_done -> DECODE_ADDRESS; else low_pkt_valid -> LOAD_PARITY; else -> LOAD_DATA.
- **LOAD_PARITY:** -> CHECK_PARITY_ERROR unconditionally.
- **CHECK_PARITY_ERROR:** fifo_full -> FIFO_FULL_STATE; else -> DECODE_ADDRESS.
- **Soft reset:** soft_reset_[addr_q]=1 in any state other than DECODE_ADDRESS forces DECODE_ADDRESS on the next edge. This overrides all other transitions. Soft resets of non-selected ports are ignored.
- **Latency:** a legal header with an empty FIFO gives detect_addr 1 cycle, then lfd 1 cycle, then ld for N payload cycles, then parity 1 cycle, then check 1 cycle. For N payload bytes with no stall, the header-to-idle latency is N+4 cycles.
- **Reset mid-packet:** asserting rst in any state returns to DECODE_ADDRESS immediately (asynchronously). No wr_en_reg pulse is generated on release.
- **Illegal state encodings:** decode to DECODE_ADDRESS.

Decomposition:
- A shared package router_pkg holds:
  - the state enum typedef (8 states, binary encoded)
  - BAD_ADDR and NUM_PORTS constants
  - a port-index typedef
- The synchronizer and register block import the same package.
- No sub-module: the next-state logic and output decode stay in a single module.
- The sel_empty/sel_soft_reset muxing is a local function, not a separate module.

Test Plan:
- Reset, then header din=2'b01 with fifo_empty_1=1, pkt_valid high for 3 cycles then low:
  - states DA, LFD, LD, LD, LP, CPE, DA
  - wr_en_reg high for exactly 3 cycles
  - busy low in DA and LD only
- Header din=2'b11 with pkt_valid=1 for 5 cycles: stays in DECODE_ADDRESS, detect_addr=1, wr_en_reg=0 throughout.
- Header din=2'b10 with fifo_empty_2=0 for 4 cycles, then 1:
  - WAIT_TILL_EMPTY for 4 cycles with busy=1
  - then LOAD_FIRST_DATA on the 5th edge
- In LOAD_DATA, fifo_full=1 for 3 cycles, then 0 with low_pkt_valid=1:
  - FIFO_FULL_STATE for 3 cycles, then LAF, LP, CPE
  - full_state high for 3 cycles, laf_state high for 1 cycle
- In LOAD_DATA for addr 0, pulse soft_reset_1 and soft_reset_0 in the same cycle: next state is DECODE_ADDRESS; soft_reset_1 alone has no effect.
- Assert rst=0 asynchronously mid-FIFO_FULL_STATE:
  - outputs return to detect_addr=1, others 0, with no clock edge
  - after release, a new header is accepted normally
